// File: rtl/box_ctrl_pkg.sv
// Shared definitions for the box frame sequencer: parameter defaults, FSM states
// and host readback selects.
package box_ctrl_pkg;

   localparam int unsigned WIDTH_DEF     = 100;
   localparam int unsigned HEIGHT_DEF    = 100;
   localparam int unsigned CMD_RESET_DEF = 99999;
   localparam int unsigned ENG_LAT_DEF   = 2;

   // CLEAR is reserved; start goes straight from IDLE/DONE to STREAM.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      FLUSH  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [2:0] SEL_XMIN = 3'd0;
   localparam logic [2:0] SEL_YMIN = 3'd1;
   localparam logic [2:0] SEL_XMAX = 3'd2;
   localparam logic [2:0] SEL_YMAX = 3'd3;
   localparam logic [2:0] SEL_STAT = 3'd4;
   localparam logic [2:0] SEL_CSUM = 3'd5;

endpackage

// File: rtl/box_pix_counter.sv
// Chained channel/x/y counters plus the next expected byte index.
// clear and advance together yield the state just after byte 0.
module box_pix_counter
   import box_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned HEIGHT = HEIGHT_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        advance_i,
   output logic [1:0]  chan_o,
   output logic [7:0]  x_o,
   output logic [7:0]  y_o,
   output logic [23:0] exp_idx_o,
   output logic        last_pixel_o
);

   localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
   localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

   logic [1:0]  chan_q, chan_d;
   logic [7:0]  x_q, x_d, y_q, y_d;
   logic [23:0] exp_q, exp_d;

   always_comb begin
      chan_d = clear_i ? '0 : chan_q;
      x_d    = clear_i ? '0 : x_q;
      y_d    = clear_i ? '0 : y_q;
      exp_d  = clear_i ? '0 : exp_q;
      if (advance_i) begin
         exp_d = exp_d + 24'd1;
         if (chan_d == 2'd2) begin
            chan_d = '0;
            if (x_d == X_LAST) begin
               x_d = '0;
               y_d = (y_d == Y_LAST) ? '0 : y_d + 8'd1;
            end else begin
               x_d = x_d + 8'd1;
            end
         end else begin
            chan_d = chan_d + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         chan_q <= '0;
         x_q    <= '0;
         y_q    <= '0;
         exp_q  <= '0;
      end else begin
         chan_q <= chan_d;
         x_q    <= x_d;
         y_q    <= y_d;
         exp_q  <= exp_d;
      end
   end

   assign chan_o       = chan_q;
   assign x_o          = x_q;
   assign y_o          = y_q;
   assign exp_idx_o    = exp_q;
   assign last_pixel_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/box_frame_ctrl.sv
// Host-to-engine frame sequencer with result latch and register readback.
// Optional frame checksum on readback select 5: define BOX_FRAME_CHECKSUM_EN.
module box_frame_ctrl
   import box_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned HEIGHT    = HEIGHT_DEF,
   parameter int unsigned CMD_RESET = CMD_RESET_DEF,
   parameter int unsigned ENG_LAT   = ENG_LAT_DEF
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] hex_value_index,
   output logic [31:0] out,
   output logic        eng_clr,
   output logic        eng_valid,
   output logic [7:0]  eng_x,
   output logic [7:0]  eng_y,
   output logic [23:0] eng_rgb,
   output logic        eng_done,
   input  logic [7:0]  eng_xmin,
   input  logic [7:0]  eng_ymin,
   input  logic [7:0]  eng_xmax,
   input  logic [7:0]  eng_ymax,
   output logic        busy
);

   localparam logic [23:0] CMD_IDX  = 24'(CMD_RESET);
   localparam logic [7:0]  LAT_LAST = 8'(ENG_LAT - 1);

   logic [23:0] idx;
   logic [7:0]  din;
   assign idx = hex_value_index[23:0];
   assign din = hex_value_index[31:24];

   state_t      state_q, state_d;
   logic [23:0] prev_idx_q;
   logic [7:0]  r_q, r_d, g_q, g_d, flush_q, flush_d;
   logic [7:0]  xmin_q, xmin_d, ymin_q, ymin_d, xmax_q, xmax_d, ymax_q, ymax_d;
   logic        err_q, err_d, fd_q, fd_d;
   logic        clr_q, clr_d, valid_q, valid_d, done_q, done_d;
   logic [7:0]  ex_q, ex_d, ey_q, ey_d;
   logic [23:0] rgb_q, rgb_d;
   logic [31:0] out_q, out_d;
   logic [15:0] csum_rd;

   logic        cmd, wr_ok, start, accept, busy_w;
   logic [1:0]  chan;
   logic [7:0]  cx, cy;
   logic [23:0] exp_idx;
   logic        last_pixel;

   // A held command index is neither re-triggered nor treated as a write.
   assign cmd    = (idx == CMD_IDX) && (prev_idx_q != CMD_IDX);
   assign wr_ok  = wr_en && (idx != CMD_IDX);
   assign start  = wr_ok && ((state_q == IDLE) || (state_q == DONE)) && (idx == '0);
   assign accept = wr_ok && (state_q == STREAM) && (idx == exp_idx);
   assign busy_w = (state_q == CLEAR) || (state_q == STREAM) || (state_q == FLUSH);

   box_pix_counter #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT)
   ) u_cnt (
      .clk_i       (CLOCK_50),
      .rst_i       (reset),
      .clear_i     (cmd | start),
      .advance_i   ((start | accept) & ~cmd),
      .chan_o      (chan),
      .x_o         (cx),
      .y_o         (cy),
      .exp_idx_o   (exp_idx),
      .last_pixel_o(last_pixel)
   );

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      g_d     = g_q;
      flush_d = flush_q;
      xmin_d  = xmin_q;
      ymin_d  = ymin_q;
      xmax_d  = xmax_q;
      ymax_d  = ymax_q;
      err_d   = err_q;
      fd_d    = fd_q;
      clr_d   = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      ex_d    = ex_q;
      ey_d    = ey_q;
      rgb_d   = rgb_q;
      if (cmd) begin
         state_d = IDLE;
         clr_d   = 1'b1;
         err_d   = 1'b0;
         fd_d    = 1'b0;
         flush_d = '0;
         xmin_d  = '0;
         ymin_d  = '0;
         xmax_d  = '0;
         ymax_d  = '0;
      end else begin
         if (wr_ok && !start && !accept) err_d = 1'b1;
         if (start) begin
            r_d     = din;
            clr_d   = 1'b1;
            fd_d    = 1'b0;
            state_d = STREAM;
         end
         if (accept) begin
            case (chan)
               2'd0:    r_d = din;
               2'd1:    g_d = din;
               default: begin
                  valid_d = 1'b1;
                  ex_d    = cx;
                  ey_d    = cy;
                  rgb_d   = {r_q, g_q, din};
                  if (last_pixel) begin
                     state_d = FLUSH;
                     flush_d = '0;
                  end
               end
            endcase
         end
         if (state_q == FLUSH) begin
            if (flush_q == LAT_LAST) begin
               done_d  = 1'b1;
               fd_d    = 1'b1;
               xmin_d  = eng_xmin;
               ymin_d  = eng_ymin;
               xmax_d  = eng_xmax;
               ymax_d  = eng_ymax;
               state_d = DONE;
            end else begin
               flush_d = flush_q + 8'd1;
            end
         end
      end
   end

   always_comb begin
      out_d = out_q;
      if (rd_en) begin
         case (idx[2:0])
            SEL_XMIN: out_d = {24'b0, xmin_q};
            SEL_YMIN: out_d = {24'b0, ymin_q};
            SEL_XMAX: out_d = {24'b0, xmax_q};
            SEL_YMAX: out_d = {24'b0, ymax_q};
            SEL_STAT: out_d = {26'b0, err_q, fd_q, busy_w, state_q};
            SEL_CSUM: out_d = {16'b0, csum_rd};
            default:  out_d = '0;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= IDLE;
         prev_idx_q <= '0;
         r_q        <= '0;
         g_q        <= '0;
         flush_q    <= '0;
         xmin_q     <= '0;
         ymin_q     <= '0;
         xmax_q     <= '0;
         ymax_q     <= '0;
         err_q      <= 1'b0;
         fd_q       <= 1'b0;
         clr_q      <= 1'b0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         ex_q       <= '0;
         ey_q       <= '0;
         rgb_q      <= '0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         prev_idx_q <= idx;
         r_q        <= r_d;
         g_q        <= g_d;
         flush_q    <= flush_d;
         xmin_q     <= xmin_d;
         ymin_q     <= ymin_d;
         xmax_q     <= xmax_d;
         ymax_q     <= ymax_d;
         err_q      <= err_d;
         fd_q       <= fd_d;
         clr_q      <= clr_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         ex_q       <= ex_d;
         ey_q       <= ey_d;
         rgb_q      <= rgb_d;
         out_q      <= out_d;
      end
   end

`ifdef BOX_FRAME_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (cmd)         csum_d = '0;
      else if (start)  csum_d = {8'b0, din};
      else if (accept) csum_d = csum_q + {8'b0, din};
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) csum_q <= '0;
      else       csum_q <= csum_d;
   end

   assign csum_rd = csum_q;
`else
   assign csum_rd = '0;
`endif

   assign out       = out_q;
   assign eng_clr   = clr_q;
   assign eng_valid = valid_q;
   assign eng_x     = ex_q;
   assign eng_y     = ey_q;
   assign eng_rgb   = rgb_q;
   assign eng_done  = done_q;
   assign busy      = busy_w;

endmodule

// File: tb/tb_box_frame_ctrl.sv
// Self-checking bench for box_frame_ctrl: vector table, randomized frames and
// a pixel-level reference model of the byte-index mapping.
module tb_box_frame_ctrl;

   localparam int W   = 100;
   localparam int H   = 100;
   localparam int CMD = 99999;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] hvi = '0;
   logic [31:0] out;
   logic        eng_clr, eng_valid, eng_done, busy;
   logic [7:0]  eng_x, eng_y;
   logic [23:0] eng_rgb;
   logic [7:0]  e_xmin = '0, e_ymin = '0, e_xmax = '0, e_ymax = '0;

   box_frame_ctrl #(
      .WIDTH    (W),
      .HEIGHT   (H),
      .CMD_RESET(CMD),
      .ENG_LAT  (2)
   ) dut (
      .CLOCK_50       (CLOCK_50),
      .reset          (reset),
      .wr_en          (wr_en),
      .rd_en          (rd_en),
      .hex_value_index(hvi),
      .out            (out),
      .eng_clr        (eng_clr),
      .eng_valid      (eng_valid),
      .eng_x          (eng_x),
      .eng_y          (eng_y),
      .eng_rgb        (eng_rgb),
      .eng_done       (eng_done),
      .eng_xmin       (e_xmin),
      .eng_ymin       (e_ymin),
      .eng_xmax       (e_xmax),
      .eng_ymax       (e_ymax),
      .busy           (busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: byte index -> (channel, pixel) by plain division.
   typedef struct {
      int          due;
      int          x;
      int          y;
      logic [23:0] rgb;
   } pix_t;

   pix_t        pq[$];
   pix_t        mp;
   int          m_next = 0;
   bit          m_stream = 1'b0;
   logic [7:0]  m_r = '0, m_g = '0;
   logic [23:0] m_prev = '0;

   int valid_cnt = 0, done_cnt = 0, last_valid_cyc = 0, done_cyc = 0;
   int last_x = 0, last_y = 0;

   task automatic apply(input logic w, input logic r, input logic [31:0] h);
      logic [23:0] i;
      int          pix;
      i = h[23:0];
      if (i == 24'(CMD) && m_prev != 24'(CMD)) begin
         m_stream = 1'b0;
      end else if (w && i != 24'(CMD)) begin
         if (!m_stream && i == '0) begin
            m_stream = 1'b1;
            m_next   = 1;
            m_r      = h[31:24];
         end else if (m_stream && int'(i) == m_next) begin
            pix = m_next / 3;
            case (m_next % 3)
               0: m_r = h[31:24];
               1: m_g = h[31:24];
               default: pq.push_back('{cyc + 1, pix % W, pix / W, {m_r, m_g, h[31:24]}});
            endcase
            m_next++;
            if (m_next == 3 * W * H) m_stream = 1'b0;
         end
      end
      m_prev = i;
      wr_en  = w;
      rd_en  = r;
      hvi    = h;
      @(posedge CLOCK_50);
      #1;
   endtask

   always @(negedge CLOCK_50) begin
      if (!reset) begin
         if (eng_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            last_x = int'(eng_x);
            last_y = int'(eng_y);
            if (pq.size() == 0) begin
               chk("valid_unexpected", {31'b0, eng_valid}, 32'd0);
            end else begin
               mp = pq.pop_front();
               chk("valid_cycle", cyc, mp.due);
               chk("valid_x", {24'b0, eng_x}, 32'(mp.x));
               chk("valid_y", {24'b0, eng_y}, 32'(mp.y));
               chk("valid_rgb", {8'b0, eng_rgb}, {8'b0, mp.rgb});
            end
         end else if (pq.size() > 0 && pq[0].due < cyc) begin
            chk("valid_missing", {31'b0, eng_valid}, 32'd1);
            void'(pq.pop_front());
         end
         if (eng_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic rdchk(input string nm, input logic [2:0] sel, input logic [31:0] exp);
      apply(1'b0, 1'b1, {29'b0, sel});
      chk(nm, out, exp);
   endtask

   task automatic send_bytes(input int n, input bit rnd, input bit gaps);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = rnd ? 8'($urandom) : 8'h01;
         if (gaps && $urandom_range(0, 7) == 0) apply(1'b0, 1'b0, {8'h00, 24'(i)});
         apply(1'b1, 1'b0, {d, 24'(i)});
         if (i == 0) begin
            chk("start_clr", {31'b0, eng_clr}, 32'd1);
            chk("start_busy", {31'b0, busy}, 32'd1);
         end
      end
   endtask

   task automatic finish_frame(input int v0, input int d0);
      for (int k = 0; k < 10 && done_cnt == d0; k++) apply(1'b0, 1'b0, '0);
      chk("done_seen", done_cnt, d0 + 1);
      chk("done_latency", done_cyc - last_valid_cyc, 32'd2);
      chk("valid_count", valid_cnt - v0, W * H);
      chk("last_x", last_x, W - 1);
      chk("last_y", last_y, H - 1);
      chk("flush_drained", pq.size(), 0);
   endtask

   typedef struct {
      bit          wr;
      bit          rd;
      logic [31:0] h;
      bit          e_clr;
      bit          e_valid;
      logic [7:0]  e_x;
      logic [7:0]  e_y;
      logic [23:0] e_rgb;
      bit          c_out;
      logic [31:0] e_out;
   } vec_t;

   vec_t tbl[18];
   int   v0, d0;
   logic [31:0] csum_exp;

   initial begin
      // idx 0..14 with idx 7 skipped once, status reads at idx 4 (rd only) and idx 12 (with write)
      tbl[0]  = '{1, 0, 32'h11_000000, 1, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 32'h22_000001, 0, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 0, 32'h33_000002, 0, 1, 0, 0, 24'h112233, 0, 0};
      tbl[3]  = '{1, 0, 32'h44_000003, 0, 0, 0, 0, 0, 0, 0};
      tbl[4]  = '{1, 0, 32'h55_000004, 0, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{1, 0, 32'h66_000005, 0, 1, 1, 0, 24'h445566, 0, 0};
      tbl[6]  = '{1, 0, 32'h77_000006, 0, 0, 0, 0, 0, 0, 0};
      tbl[7]  = '{1, 0, 32'h99_000008, 0, 0, 0, 0, 0, 0, 0};
      tbl[8]  = '{0, 1, 32'h00_000004, 0, 0, 0, 0, 0, 1, 32'h2A};
      tbl[9]  = '{1, 0, 32'h99_000008, 0, 0, 0, 0, 0, 0, 0};
      tbl[10] = '{1, 0, 32'h88_000007, 0, 0, 0, 0, 0, 0, 0};
      tbl[11] = '{1, 0, 32'h99_000008, 0, 1, 2, 0, 24'h778899, 0, 0};
      tbl[12] = '{1, 1, 32'hAA_000009, 0, 0, 0, 0, 0, 1, 32'h0};
      tbl[13] = '{1, 0, 32'hBB_00000A, 0, 0, 0, 0, 0, 0, 0};
      tbl[14] = '{1, 0, 32'hCC_00000B, 0, 1, 3, 0, 24'hAABBCC, 0, 0};
      tbl[15] = '{1, 1, 32'hDD_00000C, 0, 0, 0, 0, 0, 1, 32'h2A};
      tbl[16] = '{1, 0, 32'hEE_00000D, 0, 0, 0, 0, 0, 0, 0};
      tbl[17] = '{1, 0, 32'hFF_00000E, 0, 1, 4, 0, 24'hDDEEFF, 0, 0};

      // reset
      reset = 1'b1;
      apply(1'b0, 1'b0, '0);
      apply(1'b0, 1'b0, '0);
      chk("rst_out", out, 32'd0);
      chk("rst_clr", {31'b0, eng_clr}, 32'd0);
      chk("rst_valid", {31'b0, eng_valid}, 32'd0);
      chk("rst_done", {31'b0, eng_done}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      reset = 1'b0;
      rdchk("rst_status", 3'd4, 32'd0);

      // vector table: pixel assembly, skipped index, concurrent read/write
      for (int i = 0; i < 18; i++) begin
         apply(tbl[i].wr, tbl[i].rd, tbl[i].h);
         chk($sformatf("tbl%0d_clr", i), {31'b0, eng_clr}, {31'b0, tbl[i].e_clr});
         chk($sformatf("tbl%0d_valid", i), {31'b0, eng_valid}, {31'b0, tbl[i].e_valid});
         if (tbl[i].e_valid) begin
            chk($sformatf("tbl%0d_x", i), {24'b0, eng_x}, {24'b0, tbl[i].e_x});
            chk($sformatf("tbl%0d_y", i), {24'b0, eng_y}, {24'b0, tbl[i].e_y});
            chk($sformatf("tbl%0d_rgb", i), {8'b0, eng_rgb}, {8'b0, tbl[i].e_rgb});
         end
         if (tbl[i].c_out) chk($sformatf("tbl%0d_out", i), out, tbl[i].e_out);
      end

      // command clears err; held index does not retrigger
      apply(1'b0, 1'b0, 32'(CMD));
      chk("cmd1_clr", {31'b0, eng_clr}, 32'd1);
      chk("cmd1_busy", {31'b0, busy}, 32'd0);
      apply(1'b0, 1'b0, 32'(CMD));
      chk("cmd1_hold_clr", {31'b0, eng_clr}, 32'd0);
      apply(1'b0, 1'b0, 32'(CMD + 1));
      chk("cmd1_after_clr", {31'b0, eng_clr}, 32'd0);
      rdchk("cmd1_status", 3'd4, 32'd0);

      // full randomized frame
      e_xmin = 8'd28; e_ymin = 8'd34; e_xmax = 8'd69; e_ymax = 8'd78;
      v0 = valid_cnt; d0 = done_cnt;
      send_bytes(3 * W * H, 1'b1, 1'b1);
      finish_frame(v0, d0);
      rdchk("f1_xmin", 3'd0, 32'd28);
      rdchk("f1_ymin", 3'd1, 32'd34);
      rdchk("f1_xmax", 3'd2, 32'd69);
      rdchk("f1_ymax", 3'd3, 32'd78);
      rdchk("f1_status", 3'd4, 32'h14);
      rdchk("f1_sel6", 3'd6, 32'd0);

      // mid-frame command at pixel 5000
      d0 = done_cnt;
      send_bytes(15000, 1'b1, 1'b0);
      apply(1'b0, 1'b0, 32'(CMD));
      chk("cmd2_clr", {31'b0, eng_clr}, 32'd1);
      apply(1'b0, 1'b0, 32'(CMD + 1));
      chk("cmd2_single_clr", {31'b0, eng_clr}, 32'd0);
      rdchk("cmd2_status", 3'd4, 32'd0);
      rdchk("cmd2_xmin_cleared", 3'd0, 32'd0);
      for (int k = 0; k < 4; k++) apply(1'b0, 1'b0, '0);
      chk("cmd2_no_done", done_cnt, d0);

      // all-0x01 frame
      e_xmin = 8'd4; e_ymin = 8'd16; e_xmax = 8'd84; e_ymax = 8'd77;
      v0 = valid_cnt; d0 = done_cnt;
      send_bytes(3 * W * H, 1'b0, 1'b0);
      finish_frame(v0, d0);
      rdchk("f2_xmin", 3'd0, 32'd4);
      rdchk("f2_ymin", 3'd1, 32'd16);
      rdchk("f2_xmax", 3'd2, 32'd84);
      rdchk("f2_ymax", 3'd3, 32'd77);
      rdchk("f2_status", 3'd4, 32'h14);
`ifdef BOX_FRAME_CHECKSUM_EN
      csum_exp = 32'((3 * W * H) % 65536);
`else
      csum_exp = 32'd0;
`endif
      rdchk("f2_csum", 3'd5, csum_exp);
      apply(1'b0, 1'b0, 32'd5);
      chk("out_hold", out, csum_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/box_frame_ctrl.md
Name: box_frame_ctrl

Overview:
Frame sequencer between the host word interface and the bounding-box engine. Decodes the packed index/data write stream and tracks channel/x/y with counters. Assembles RGB pixels and issues clear / pixel-valid / frame-done to the engine. Latches the engine's xMin/yMin/xMax/yMax at frame end and serves register readback to the host.

Parameters:
WIDTH, 100, image width in pixels
HEIGHT, 100, image height in pixels
CMD_RESET, 99999, index value that acts as the soft-restart command
ENG_LAT, 2, engine pipeline depth in cycles, waited before latching results

Ports:
CLOCK_50  in  1  sole clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  host write strobe
rd_en  in  1  host read strobe
hex_value_index  in  32  [23:0] byte index, command or read select; [31:24] data byte
out  out  32  registered readback data
eng_clr  out  1  one-cycle pulse; clears engine accumulators
eng_valid  out  1  one-cycle pixel strobe
eng_x  out  8  pixel column
eng_y  out  8  pixel row
eng_rgb  out  24  {R,G,B}
eng_done  out  1  one-cycle end-of-frame pulse to engine
eng_xmin, eng_ymin, eng_xmax, eng_ymax  in  8 each  engine results
busy  out  1  high in CLEAR, STREAM and FLUSH

Behaviour:
- Reset: state IDLE. All counters, latched results, out, eng_* outputs, busy, frame_done and err are 0.
- Byte index i maps to channel i%3 (0=R, 1=G, 2=B) and pixel i/3, with x=pixel%WIDTH and y=pixel/WIDTH. Mapping is done with chained counters only, with no divider. exp_idx tracks the next expected index.
- States:
  - IDLE / DONE: a wr_en with index 0 means start. The R byte is stored, exp_idx becomes 1, eng_clr pulses the next cycle, and the state goes to STREAM.
  - STREAM: a wr_en with index==exp_idx stores the byte and advances the counters.
    - On the B byte, eng_valid pulses the next cycle with x, y and {R,G,B}. Latency is 1 cycle.
    - The B byte of pixel WIDTH*HEIGHT-1 moves the state to FLUSH.
  - FLUSH: counts ENG_LAT cycles after the final eng_valid. Then eng_done pulses, eng_* results are latched, frame_done is set, and the state goes to DONE.
- Any other write index (mismatch, or a nonzero index in IDLE/DONE): sticky err=1, write dropped, counters unchanged.
- Index 0 written during STREAM or FLUSH: treated as a mismatch.
- Command (any state):
  - Trigger: hex_value_index[23:0]==CMD_RESET on a cycle whose previous index differed. Edge-detected; wr_en is ignored.
  - Action: eng_clr pulses next cycle; state IDLE; counters, frame_done, err and latched results are cleared.
  - Priority: a command beats a same-cycle write.
- Readback: on rd_en, out updates the next cycle by index[2:0]:
  - 0 xMin, 1 yMin, 2 xMax, 3 yMax
  - 4 status {26'b0, err, frame_done, busy, state[2:0]}
  - 5 checksum (see Optional Feature)
  - others 0
  - out holds its value while rd_en=0.
- rd_en and wr_en in the same cycle: both are serviced independently.
- Reset asserted mid-frame: same as power-up reset. No eng_done pulse.

Optional Feature:
- Macro: BOX_FRAME_CHECKSUM_EN.
- Defined: a 16-bit wrapping sum of every accepted data byte in the current frame. It clears on start and on command, and is frozen in DONE. Read select 5 returns {16'b0, sum}.
- Undefined: no adder; select 5 reads 0.

Decomposition:
- Package box_ctrl_pkg:
  - WIDTH, HEIGHT, CMD_RESET and ENG_LAT defaults
  - state enum (IDLE, STREAM, FLUSH, DONE, plus CLEAR reserved, 3-bit)
  - readback select constants (SEL_XMIN through SEL_CSUM)
- Sub-module box_pix_counter: channel/x/y/exp_idx counters with advance and clear inputs, plus a last_pixel flag.

Test Plan:
- Reset: assert reset 2 cycles -> state IDLE, out=0, eng_clr/eng_valid/eng_done=0, busy=0.
- Pixel assembly: write idx 0-5 = 11,22,33,44,55,66 -> eng_valid at x=0,y=0,rgb=0x112233, then 1 cycle after idx 5, x=1,y=0,rgb=0x445566.
- Full frame: 30000 in-order writes with the engine model returning 28,34,69,78 -> 10000 eng_valid pulses, the last at x=99,y=99. eng_done follows 2 cycles later; sel 0-3 read 28,34,69,78; status frame_done=1, busy=0.
- Error: skip idx 7 -> err=1, status bit set, exp_idx stays 7, no eng_valid for pixel 2 until idx 7 is written.
- Mid-frame command: index=CMD_RESET at pixel 5000, then CMD_RESET+1 -> single eng_clr pulse, state IDLE, frame_done=0. A following frame with engine model 4,16,84,77 reads back 4,16,84,77.
- Concurrency/checksum: rd_en with sel 4 during a STREAM write -> write accepted and status read next cycle. With BOX_FRAME_CHECKSUM_EN, a frame of all-0x01 bytes gives sel 5 = 30000 mod 65536 = 0x7530.
